spi_master: RTL and testbench

SPI master transmitter for the SPI memory interface. Its outputs (sclk, cs, mosi) are the noisy pins that the slave side passes through its input conditioners. It serializes one 16-bit frame per request: 7-bit address, R/W bit, then 8 data bits. On reads it captures the slave's miso data. It paces sclk slowly enough for the slave's synchronizer and debouncer to resolve every edge.

---
 rtl/spi_master.sv | 155 +++++++++++++++
 tb/tb_spi_master.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// spi_master: mode-0 SPI frame transmitter. Sends one 16-bit frame
// {addr[6:0], rw, data[7:0]} MSB first per accepted start. On reads it
// captures the slave's reply byte from miso. Every sclk phase lasts
// CLKDIV clk cycles, so a slow input conditioner on the slave can resolve
// each edge. All pin-level outputs come straight from flops.

module spi_master #(
    parameter int CLKDIV = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    input  logic       miso,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       sclk,
    output logic       cs,
    output logic       mosi
);

    typedef enum logic [2:0] {
        IDLE,
        LOW,
        HIGH,
        HOLD,
        GAP,
        DONE
    } state_t;

    // $clog2(1) is 0, so a one-cycle divider still needs a 1-bit counter.
    localparam int             DW       = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [DW-1:0]  DIV_LAST = DW'(CLKDIV - 1);

    state_t        state, state_n;
    logic [DW-1:0] div_cnt, div_cnt_n;
    logic [3:0]    bit_cnt, bit_cnt_n;
    logic [15:0]   frame, frame_n;
    logic          rw_q, rw_n;
    logic [7:0]    cap, cap_n;
    logic [7:0]    rdata_n;
    logic          phase_end;

    logic          busy_n, done_n, sclk_n, cs_n, mosi_n;

    assign phase_end = (div_cnt == DIV_LAST);

    // State, datapath and output registers; reset abandons any frame at once.
    always_ff @(posedge clk) begin
        // NOTE: every flop here is assigned with <= so all registers update
        // from the same pre-edge values; a blocking = would let later lines
        // see already-updated state and silently change the behaviour.
        if (reset) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            frame   <= '0;
            rw_q    <= 1'b0;
            cap     <= '0;
            rdata   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sclk    <= 1'b0;
            cs      <= 1'b1;
            mosi    <= 1'b0;
        end else begin
            state   <= state_n;
            div_cnt <= div_cnt_n;
            bit_cnt <= bit_cnt_n;
            frame   <= frame_n;
            rw_q    <= rw_n;
            cap     <= cap_n;
            rdata   <= rdata_n;
            busy    <= busy_n;
            done    <= done_n;
            sclk    <= sclk_n;
            cs      <= cs_n;
            mosi    <= mosi_n;
        end
    end

    // Next state plus the counters, frame latch and read capture that move with it.
    always_comb begin
        // NOTE: each variable gets a default before the case so that paths
        // which do not mention it hold the register value instead of
        // inferring a latch.
        state_n   = state;
        bit_cnt_n = bit_cnt;
        frame_n   = frame;
        rw_n      = rw_q;
        cap_n     = cap;
        rdata_n   = rdata;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n   = LOW;
                    bit_cnt_n = 4'd15;
                    frame_n   = {addr, rw, (rw ? 8'h00 : wdata)};
                    rw_n      = rw;
                end else begin
                    state_n = IDLE;
                end
            end
            LOW: begin
                if (phase_end) state_n = HIGH;
            end
            HIGH: begin
                // Data bits 7..0 are sampled at the end of their high phase.
                if (phase_end && (bit_cnt <= 4'd7)) cap_n = {cap[6:0], miso};
                if (phase_end) begin
                    if (bit_cnt == 4'd0) begin
                        state_n = HOLD;
                    end else begin
                        state_n   = LOW;
                        bit_cnt_n = bit_cnt - 1'b1;
                    end
                end
            end
            HOLD: begin
                if (phase_end) state_n = GAP;
            end
            GAP: begin
                if (phase_end) begin
                    state_n = DONE;
                    // rdata only follows read frames; writes leave it alone.
                    if (rw_q) rdata_n = cap;
                end
            end
            default: state_n = IDLE;
        endcase

        // The divider restarts on every state change and rests in IDLE.
        if ((state_n != state) || (state == IDLE)) begin
            div_cnt_n = '0;
        end else begin
            div_cnt_n = div_cnt + 1'b1;
        end
    end

    // Pin values decoded from the upcoming state so they land in flops.
    always_comb begin
        busy_n = (state_n == LOW) || (state_n == HIGH) ||
                 (state_n == HOLD) || (state_n == GAP);
        cs_n   = !((state_n == LOW) || (state_n == HIGH) || (state_n == HOLD));
        sclk_n = (state_n == HIGH);
        done_n = (state_n == DONE);
        // The bit index only steps on HIGH->LOW, so mosi moves with sclk falling.
        mosi_n = ((state_n == LOW) || (state_n == HIGH)) ? frame_n[bit_cnt_n] : 1'b0;
    end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed bench for spi_master with one CLKDIV=4 instance and
// one CLKDIV=1 instance. Pin monitors rebuild each frame from mosi at sclk
// rises, time the cs and done events and play a simple read slave on miso.

module tb_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // CLKDIV=4 instance
    logic       s4_start, s4_rw, s4_miso;
    logic [6:0] s4_addr;
    logic [7:0] s4_wdata, s4_rdata;
    logic       s4_busy, s4_done, s4_sclk, s4_cs, s4_mosi;

    // CLKDIV=1 instance
    logic       s1_start, s1_rw, s1_miso;
    logic [6:0] s1_addr;
    logic [7:0] s1_wdata, s1_rdata;
    logic       s1_busy, s1_done, s1_sclk, s1_cs, s1_mosi;

    spi_master #(.CLKDIV(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(s4_start), .rw(s4_rw),
        .addr(s4_addr), .wdata(s4_wdata), .miso(s4_miso),
        .busy(s4_busy), .done(s4_done), .rdata(s4_rdata),
        .sclk(s4_sclk), .cs(s4_cs), .mosi(s4_mosi)
    );

    spi_master #(.CLKDIV(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(s1_start), .rw(s1_rw),
        .addr(s1_addr), .wdata(s1_wdata), .miso(s1_miso),
        .busy(s1_busy), .done(s1_done), .rdata(s1_rdata),
        .sclk(s1_sclk), .cs(s1_cs), .mosi(s1_mosi)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // ---------------- CLKDIV=4 pin monitor and read slave ----------------
    logic [7:0]  slave_byte = 8'h00;
    logic        p4_sclk = 1'b0, p4_cs = 1'b1, p4_mosi = 1'b0;
    logic [15:0] m4_frame = '0;
    int m4_rises = 0, m4_first_rise = 0, m4_last_rise = 0, m4_spacing_bad = 0;
    int m4_falls = 0, m4_cs_fall = 0, m4_cs_rise = 0, m4_high_run = 0;
    int m4_last_gap = 0, m4_done_cnt = 0, m4_mosi_bad = 0;

    initial s4_miso = 1'b0;

    always @(negedge clk) begin
        if (p4_cs && !s4_cs) begin
            m4_cs_fall  = cyc;
            m4_rises    = 0;
            m4_falls    = 0;
            m4_frame    = '0;
            m4_last_gap = m4_high_run;
            s4_miso     = 1'b0;
        end
        if (!p4_cs && s4_cs) begin
            m4_cs_rise  = cyc;
            m4_high_run = 0;
        end
        if (s4_cs) m4_high_run++;
        if (!p4_sclk && s4_sclk) begin
            m4_frame = {m4_frame[14:0], s4_mosi};
            if (m4_rises == 0) m4_first_rise = cyc;
            else if (cyc - m4_last_rise != 8) m4_spacing_bad++;
            m4_last_rise = cyc;
            m4_rises++;
        end
        if (p4_sclk && !s4_sclk) begin
            m4_falls++;
            // Slave presents reply bit 7..0 after the 8th..15th sclk fall.
            if (m4_falls >= 8 && m4_falls <= 15) s4_miso = slave_byte[3'(15 - m4_falls)];
        end
        if ((s4_mosi !== p4_mosi) && !(p4_sclk && !s4_sclk) && (p4_cs == s4_cs)) m4_mosi_bad++;
        if (s4_done) m4_done_cnt++;
        p4_sclk = s4_sclk;
        p4_cs   = s4_cs;
        p4_mosi = s4_mosi;
    end

    // ---------------- CLKDIV=1 pin monitor ----------------
    logic        p1_sclk = 1'b0, p1_cs = 1'b1;
    logic [15:0] m1_frame = '0;

    always @(negedge clk) begin
        if (p1_cs && !s1_cs) m1_frame = '0;
        if (!p1_sclk && s1_sclk) m1_frame = {m1_frame[14:0], s1_mosi};
        p1_sclk = s1_sclk;
        p1_cs   = s1_cs;
    end

    // Called at a negedge; start is sampled by the edge closing cycle t0.
    task automatic start4(input logic rw, input logic [6:0] addr, input logic [7:0] wdata,
                          output int t0);
        s4_rw    = rw;
        s4_addr  = addr;
        s4_wdata = wdata;
        s4_start = 1'b1;
        t0       = cyc;
        @(posedge clk);
        #1 s4_start = 1'b0;
    endtask

    task automatic wait_done4(input int budget, output int at, output bit ok);
        ok = 1'b0;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (s4_done) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, at, at2, d0;
        bit ok;

        reset    = 1'b1;
        s4_start = 1'b0; s4_rw = 1'b0; s4_addr = '0; s4_wdata = '0;
        s1_start = 1'b0; s1_rw = 1'b0; s1_addr = '0; s1_wdata = '0; s1_miso = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // ---- reset for two cycles while idle ----
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst.cs",    32'(s4_cs),    1);
        check("rst.sclk",  32'(s4_sclk),  0);
        check("rst.mosi",  32'(s4_mosi),  0);
        check("rst.busy",  32'(s4_busy),  0);
        check("rst.done",  32'(s4_done),  0);
        check("rst.rdata", 32'(s4_rdata), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // ---- write 7'h55 <- 8'hA3, slave drives 1s to expose a wrong rdata load ----
        slave_byte = 8'hFF;
        start4(1'b0, 7'h55, 8'hA3, t0);
        @(negedge clk);
        check("w.first.busy", 32'(s4_busy), 1);
        check("w.first.cs",   32'(s4_cs),   0);
        check("w.first.sclk", 32'(s4_sclk), 0);
        check("w.first.mosi", 32'(s4_mosi), 1);
        wait_done4(300, at, ok);
        check("w.done_seen",   32'(ok), 1);
        check("w.done_time",   at, t0 + 137);
        check("w.busy_at_done", 32'(s4_busy), 0);
        check("w.rdata",       32'(s4_rdata), 0);
        check("w.frame",       32'(m4_frame), 'hAAA3);
        check("w.rises",       m4_rises, 16);
        check("w.spacing",     m4_spacing_bad, 0);
        check("w.first_rise",  m4_first_rise, t0 + 5);
        check("w.cs_fall",     m4_cs_fall, t0 + 1);
        check("w.cs_low_len",  m4_cs_rise - m4_cs_fall, 132);
        @(negedge clk);
        check("w.done_pulse",  32'(s4_done), 0);
        repeat (4) @(negedge clk);

        // ---- read 7'h12, slave replies 8'h5C ----
        slave_byte = 8'h5C;
        start4(1'b1, 7'h12, 8'hFF, t0);
        wait_done4(300, at, ok);
        check("r.done_seen", 32'(ok), 1);
        check("r.done_time", at, t0 + 137);
        check("r.rdata",     32'(s4_rdata), 'h5C);
        check("r.frame",     32'(m4_frame), 'h2500);
        repeat (4) @(negedge clk);

        // ---- start pulse mid-frame is ignored; inputs change after acceptance ----
        slave_byte = 8'hFF;
        d0 = m4_done_cnt;
        start4(1'b0, 7'h33, 8'h0F, t0);
        while (cyc < t0 + 40) @(negedge clk);
        s4_addr  = 7'h01;
        s4_wdata = 8'hEE;
        s4_rw    = 1'b1;
        s4_start = 1'b1;
        @(posedge clk);
        #1 s4_start = 1'b0;
        wait_done4(300, at, ok);
        check("b.done_seen", 32'(ok), 1);
        check("b.done_time", at, t0 + 137);
        check("b.frame",     32'(m4_frame), 'h660F);
        check("b.rdata",     32'(s4_rdata), 'h5C);
        repeat (20) @(negedge clk);
        check("b.one_done",  m4_done_cnt - d0, 1);
        check("b.idle_busy", 32'(s4_busy), 0);
        check("b.idle_cs",   32'(s4_cs), 1);

        // ---- start held high: back-to-back frames ----
        s4_rw    = 1'b0;
        s4_addr  = 7'h0A;
        s4_wdata = 8'h3C;
        s4_start = 1'b1;
        t0       = cyc;
        wait_done4(300, at, ok);
        check("bb.done1_seen", 32'(ok), 1);
        check("bb.done1_time", at, t0 + 137);
        check("bb.frame1",     32'(m4_frame), 'h143C);
        repeat (2) @(negedge clk);
        check("bb.cs_fall2",   m4_cs_fall, t0 + 138);
        check("bb.cs_gap",     m4_last_gap, 5);
        s4_start = 1'b0;
        wait_done4(300, at2, ok);
        check("bb.done2_seen", 32'(ok), 1);
        check("bb.done2_time", at2, at + 137);
        check("bb.frame2",     32'(m4_frame), 'h143C);
        repeat (4) @(negedge clk);

        // ---- reset in the middle of a frame ----
        d0 = m4_done_cnt;
        start4(1'b0, 7'h55, 8'hA3, t0);
        while (cyc < t0 + 60) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mr.cs",    32'(s4_cs),    1);
        check("mr.sclk",  32'(s4_sclk),  0);
        check("mr.mosi",  32'(s4_mosi),  0);
        check("mr.busy",  32'(s4_busy),  0);
        check("mr.done",  32'(s4_done),  0);
        check("mr.rdata", 32'(s4_rdata), 0);
        reset = 1'b0;
        repeat (150) @(negedge clk);
        check("mr.no_done", m4_done_cnt - d0, 0);
        start4(1'b0, 7'h2B, 8'h96, t0);
        wait_done4(300, at, ok);
        check("mr.done_seen", 32'(ok), 1);
        check("mr.done_time", at, t0 + 137);
        check("mr.frame",     32'(m4_frame), 'h5696);
        check("mr.rises",     m4_rises, 16);
        repeat (4) @(negedge clk);

        // ---- CLKDIV=1 write 7'h7F <- 8'hFF ----
        s1_rw    = 1'b0;
        s1_addr  = 7'h7F;
        s1_wdata = 8'hFF;
        s1_start = 1'b1;
        t0       = cyc;
        @(posedge clk);
        #1 s1_start = 1'b0;
        ok = 1'b0;
        at = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (s1_done) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
        check("d1.done_seen", 32'(ok), 1);
        check("d1.done_time", at, t0 + 35);
        check("d1.busy",      32'(s1_busy), 0);
        check("d1.frame",     32'(m1_frame), 'hFEFF);

        check("mosi_stable", m4_mosi_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
